// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = producer/consumer side, slave = the sequencer itself.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow_out, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow_out, busy
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin through one full-subtractor cell, LSB first; result valid WIDTH cycles after accept.
// Result is held in DONE until out_ready; operands are refused (in_ready low) outside IDLE.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             bout_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic             d;
    logic             br_nxt;

    assign d        = sa[0] ^ sb[0] ^ br;
    assign br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                accept   = bus.in_valid & ~rst;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.b;
            br  <= bus.bin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa <= {1'b0, sa[WIDTH-1:1]};
            sb <= {1'b0, sb[WIDTH-1:1]};
            sd <= {d, sd[WIDTH-1:1]};
            br <= br_nxt;
            // Hold the counter on the final bit so it never wraps mid-operation.
            if (last_bit) begin
                diff_q <= {d, sd[WIDTH-1:1]};
                bout_q <= br_nxt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 directed cases plus WIDTH=2 exhaustive.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8)) x8();
    serial_sub_ctrl_if #(.WIDTH(2)) x2();

    serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(x8.slave));
    serial_sub_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(x2.slave));

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] e8;
    logic [2:0] e2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] ua, input logic [7:0] ub, input logic ubin, input bit push);
        int n = 0;
        x8.a = ua; x8.b = ub; x8.bin = ubin; x8.in_valid = 1'b1;
        while (!x8.in_ready && n < 100) begin step(); n++; end
        if (!x8.in_ready) chk("accept8_timeout", 0, 1);
        else if (push) q8.push_back({1'b0, ua} - {1'b0, ub} - 9'(ubin));
        step();
        x8.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] ua, input logic [1:0] ub, input logic ubin);
        int n = 0;
        x2.a = ua; x2.b = ub; x2.bin = ubin; x2.in_valid = 1'b1;
        while (!x2.in_ready && n < 100) begin step(); n++; end
        if (!x2.in_ready) chk("accept2_timeout", 0, 1);
        else q2.push_back({1'b0, ua} - {1'b0, ub} - 3'(ubin));
        step();
        x2.in_valid = 1'b0;
    endtask

    task automatic wait_out8();
        int n = 0;
        while (!x8.out_valid && n < 100) begin step(); n++; end
        if (!x8.out_valid) chk("out8_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 500) begin step(); n++; end
        chk("drain_left", 64'(q8.size() + q2.size()), 0);
    endtask

    // Results are checked on the cycle the output handshake is seen.
    always @(negedge clk) begin
        if (!rst && x8.out_valid && x8.out_ready) begin
            if (q8.size() == 0) chk("spurious8", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("res8", {x8.borrow_out, x8.diff}, e8);
            end
        end
        if (!rst && x2.out_valid && x2.out_ready) begin
            if (q2.size() == 0) chk("spurious2", 1, 0);
            else begin
                e2 = q2.pop_front();
                chk("res2", {x2.borrow_out, x2.diff}, e2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int k;
        x8.in_valid = 1'b0; x8.a = '0; x8.b = '0; x8.bin = 1'b0; x8.out_ready = 1'b1;
        x2.in_valid = 1'b0; x2.a = '0; x2.b = '0; x2.bin = 1'b0; x2.out_ready = 1'b1;

        step(); step();
        chk("rst_in_ready", x8.in_ready, 0);
        chk("rst_out_valid", x8.out_valid, 0);
        chk("rst_busy", x8.busy, 0);
        chk("rst_diff", x8.diff, 0);
        chk("rst_borrow", x8.borrow_out, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", x8.in_ready, 1);

        // Latency and first result
        send8(8'h5A, 8'h3C, 1'b0, 1'b1);
        k = 0;
        do begin step(); k++; end while (!x8.out_valid && k < 50);
        chk("latency", k, 8);
        step();
        chk("in_ready_after_done", x8.in_ready, 1);
        chk("out_valid_after_done", x8.out_valid, 0);

        // Borrow corner cases, back to back
        send8(8'h00, 8'h01, 1'b0, 1'b1);
        send8(8'hFF, 8'hFF, 1'b1, 1'b1);
        send8(8'h80, 8'h00, 1'b1, 1'b1);
        drain();

        // Backpressure: result must hold for all DONE cycles
        x8.out_ready = 1'b0;
        send8(8'h10, 8'h01, 1'b0, 1'b1);
        wait_out8();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", x8.out_valid, 1);
            chk("bp_diff", x8.diff, 8'h0F);
            chk("bp_borrow", x8.borrow_out, 0);
            chk("bp_in_ready", x8.in_ready, 0);
            step();
        end
        x8.out_ready = 1'b1;
        #1;
        chk("bp_valid_last", x8.out_valid, 1);
        chk("bp_diff_last", x8.diff, 8'h0F);
        step();
        chk("bp_released", x8.out_valid, 0);
        chk("bp_in_ready_back", x8.in_ready, 1);

        // Operands offered during RUN are ignored
        send8(8'hC3, 8'h12, 1'b1, 1'b1);
        x8.a = 8'hAA; x8.b = 8'h55; x8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("run_in_ready", x8.in_ready, 0);
            step();
        end
        x8.in_valid = 1'b0;
        drain();
        step(); step();
        chk("ignored_busy", x8.busy, 0);
        chk("ignored_out_valid", x8.out_valid, 0);

        // Reset in the middle of an operation discards it
        send8(8'h77, 8'h11, 1'b0, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", x8.busy, 0);
        chk("midrst_out_valid", x8.out_valid, 0);
        chk("midrst_diff", x8.diff, 0);
        chk("midrst_borrow", x8.borrow_out, 0);
        send8(8'h03, 8'h05, 1'b0, 1'b1);
        drain();

        // WIDTH=2 exhaustive
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            send2(v[4:3], v[2:1], v[0]);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
